// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the display-counter clock dividers.
//   CLK_HZ             : board clock frequency (CLOCK_50).
//   HALF_PERIOD_1HZ    : half-period in CLOCK_50 cycles for the units digit.
//   HALF_PERIOD_0P1HZ  : half-period in CLOCK_50 cycles for the tens digit.
//   cnt_width()        : width of the cycle counter for a given half-period.
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned HALF_PERIOD_1HZ   = 25_000_000;
    localparam int unsigned HALF_PERIOD_0P1HZ = 250_000_000;

    // The counter only has to hold 0 .. half_period-1, so $clog2 is enough
    // bits; a half-period of 1 still needs a one-bit counter to exist.
    function automatic int cnt_width(input int unsigned half_period);
        int w;
        w = $clog2(half_period);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : clk_div_pkg

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
// Divides CLOCK_50 down to a 50 %-duty square wave with a period of
// 2*HALF_PERIOD cycles, plus a one-cycle tick marking each rising edge.
// Downstream logic should use tick as a clock enable in the CLOCK_50 domain
// rather than clocking flops from clk_out.
//
// Ports:
//   CLOCK_50 : in  system clock, all state updates on its rising edge
//   reset    : in  synchronous active-low reset (sampled on CLOCK_50)
//   clk_out  : out divided square wave, driven directly from a flop
//   tick     : out one-cycle pulse in the first cycle clk_out is high
// -----------------------------------------------------------------------------
module clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_1HZ
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic clk_out,
    output logic tick
);

    localparam int CNT_W = cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // The counter wraps at CNT_MAX, so it can never exceed HALF_PERIOD-1.
    assign wrap = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (wrap) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            // Only the low-to-high toggle produces a tick.
            tick_d    = ~clk_out_q;
        end
    end

    // Reset wins over counting and discards any phase in progress.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_divider
// Six dividers share one clock, each with its own reset:
//   0: HALF_PERIOD=4    1: HALF_PERIOD=1    2: HALF_PERIOD=5 (reset mid-period)
//   3: HALF_PERIOD=3 (reset glitch between edges)   4: HALF_PERIOD=30
//   5: default HALF_PERIOD (never reaches its first rise in this run)
// Expected outputs come from the edge-number formula: after counting edge n
// (n-th edge sampling reset==1), clk_out = (n / HP) odd and
// tick = (n mod 2HP == HP); after a reset edge both are 0.
// -----------------------------------------------------------------------------
module tb_clk_divider;

    localparam int NI      = 6;
    localparam int NCYCLES = 603;   // 3 reset edges + 600 counting edges

    logic          CLOCK_50;
    logic [NI-1:0] rst;
    logic [NI-1:0] clk_o;
    logic [NI-1:0] tk;

    // Scoreboard entry: expected {tick, clk_out} per instance, plus the
    // expected counter value of the default-period instance.
    typedef struct packed {
        logic [NI-1:0] clk;
        logic [NI-1:0] tick;
        logic [31:0]   f_cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_edge [NI];
    int tests_run;
    int tests_failed;
    int rises_d, rises_e, high_d, high_e;
    logic prev_d, prev_e;
    bit   done;

    // ------------------------------------------------------------- clock
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ------------------------------------------------------------- DUTs
    clk_divider #(.HALF_PERIOD(4))  dut_a (.CLOCK_50(CLOCK_50), .reset(rst[0]), .clk_out(clk_o[0]), .tick(tk[0]));
    clk_divider #(.HALF_PERIOD(1))  dut_b (.CLOCK_50(CLOCK_50), .reset(rst[1]), .clk_out(clk_o[1]), .tick(tk[1]));
    clk_divider #(.HALF_PERIOD(5))  dut_c (.CLOCK_50(CLOCK_50), .reset(rst[2]), .clk_out(clk_o[2]), .tick(tk[2]));
    clk_divider #(.HALF_PERIOD(3))  dut_d (.CLOCK_50(CLOCK_50), .reset(rst[3]), .clk_out(clk_o[3]), .tick(tk[3]));
    clk_divider #(.HALF_PERIOD(30)) dut_e (.CLOCK_50(CLOCK_50), .reset(rst[4]), .clk_out(clk_o[4]), .tick(tk[4]));
    clk_divider                     dut_f (.CLOCK_50(CLOCK_50), .reset(rst[5]), .clk_out(clk_o[5]), .tick(tk[5]));

    function automatic int hp_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 5;
            3:       return 3;
            4:       return 30;
            default: return 25_000_000;
        endcase
    endfunction

    // ------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- driver
    // Sets the resets for the coming edge and pushes what every instance
    // must show after it.
    task automatic drive_cycle(input int c);
        logic [NI-1:0] r;
        exp_t          e;
        @(negedge CLOCK_50);
        for (int k = 0; k < NI; k++) begin
            r[k] = (c >= 3);
        end
        // Instance 2: reset sampled at its 7th counting edge (clk_out high).
        if (c == 9) r[2] = 1'b0;
        rst = r;
        for (int k = 0; k < NI; k++) begin
            if (!r[k]) n_edge[k] = 0;
            else       n_edge[k]++;
            e.clk[k]  = (n_edge[k] != 0) && (((n_edge[k] / hp_of(k)) % 2) == 1);
            e.tick[k] = (n_edge[k] != 0) && ((n_edge[k] % (2 * hp_of(k))) == hp_of(k));
        end
        e.f_cnt = n_edge[5] % hp_of(5);
        exp_q.push_back(e);
        // Instance 3: a reset glitch that no rising edge sees.
        if (c == 20) begin
            #1 rst[3] = 1'b0;
            #2 rst[3] = 1'b1;
        end
    endtask

    // ------------------------------------------------------------- monitor
    always @(posedge CLOCK_50) begin
        #1;
        if (!done && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int k = 0; k < NI; k++) begin
                check($sformatf("clk_out[%0d]", k), 32'(clk_o[k]), 32'(e.clk[k]));
                check($sformatf("tick[%0d]", k),    32'(tk[k]),    32'(e.tick[k]));
            end
            check("f_cnt", 32'(dut_f.cnt_q), e.f_cnt);
            if (clk_o[3] && !prev_d) rises_d++;
            if (clk_o[4] && !prev_e) rises_e++;
            if (clk_o[3]) high_d++;
            if (clk_o[4]) high_e++;
            prev_d = clk_o[3];
            prev_e = clk_o[4];
        end
    end

    // ------------------------------------------------------------- main
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rises_d = 0; rises_e = 0; high_d = 0; high_e = 0;
        prev_d = 1'b0; prev_e = 1'b0;
        done = 1'b0;
        rst  = '0;
        for (int k = 0; k < NI; k++) n_edge[k] = 0;

        for (int c = 0; c < NCYCLES; c++) begin
            drive_cycle(c);
        end
        // Let the monitor consume the last entry.
        @(posedge CLOCK_50);
        #3;
        done = 1'b1;

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("rises_hp3",   32'(rises_d), 32'd100);
        check("rises_hp30",  32'(rises_e), 32'd10);
        check("high_hp3",    32'(high_d),  32'd300);
        check("high_hp30",   32'(high_e),  32'd300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_clk_divider
